// File: rtl/serial_digit_adder_if.sv
// Operand/result handshake bundle for serial_digit_adder.
// io_out_overflow exists only when SERIAL_DIGIT_ADDER_OVERFLOW_EN is defined.
interface serial_digit_adder_if #(
  parameter int WIDTH = 8
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_lhs;
  logic [WIDTH-1:0] io_in_rhs;
  logic             io_in_cin;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_sum;
  logic             io_out_cout;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
  logic             io_out_overflow;

  modport master (
    output io_in_valid, io_in_lhs, io_in_rhs, io_in_cin, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_overflow
  );
  modport slave (
    input  io_in_valid, io_in_lhs, io_in_rhs, io_in_cin, io_out_ready,
    output io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_overflow
  );
`else
  modport master (
    output io_in_valid, io_in_lhs, io_in_rhs, io_in_cin, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_sum, io_out_cout
  );
  modport slave (
    input  io_in_valid, io_in_lhs, io_in_rhs, io_in_cin, io_out_ready,
    output io_in_ready, io_out_valid, io_out_sum, io_out_cout
  );
`endif
endinterface

// File: rtl/serial_digit_adder.sv
// Multi-cycle WIDTH-bit adder reusing a DIGIT-bit slice, LSB digit first, carry registered between cycles.
// Optional signed-overflow output enabled by SERIAL_DIGIT_ADDER_OVERFLOW_EN.
//
// state | meaning
// IDLE  | ready for an operand pair
// BUSY  | adding one digit per cycle
// DONE  | result presented until consumer takes it
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               reset,
  serial_digit_adder_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((WIDTH < DIGIT) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("serial_digit_adder: WIDTH must be a multiple of DIGIT and >= DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lhs_sh_q, lhs_sh_d;
  logic [WIDTH-1:0] rhs_sh_q, rhs_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   slice;
  logic [WIDTH+DIGIT-1:0] acc_ext;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
  logic             lhs_sign_q, lhs_sign_d;
  logic             rhs_sign_q, rhs_sign_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    lhs_sh_d = lhs_sh_q;
    rhs_sh_d = rhs_sh_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
    lhs_sign_d = lhs_sign_q;
    rhs_sign_d = rhs_sign_q;
    ovf_d      = ovf_q;
`endif
    slice   = {1'b0, lhs_sh_q[DIGIT-1:0]} + {1'b0, rhs_sh_q[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the top; the widened vector keeps this legal when NDIG == 1.
    acc_ext = {slice[DIGIT-1:0], acc_q};
    case (state_q)
      IDLE: begin
        if (bus.io_in_valid) begin
          lhs_sh_d = bus.io_in_lhs;
          rhs_sh_d = bus.io_in_rhs;
          carry_d  = bus.io_in_cin;
          cnt_d    = '0;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
          lhs_sign_d = bus.io_in_lhs[WIDTH-1];
          rhs_sign_d = bus.io_in_rhs[WIDTH-1];
`endif
          state_d  = BUSY;
        end
      end
      BUSY: begin
        carry_d  = slice[DIGIT];
        acc_d    = acc_ext[WIDTH+DIGIT-1:DIGIT];
        lhs_sh_d = lhs_sh_q >> DIGIT;
        rhs_sh_d = rhs_sh_q >> DIGIT;
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = slice[DIGIT];
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
          ovf_d   = (lhs_sign_q == rhs_sign_q) && (acc_d[WIDTH-1] != lhs_sign_q);
`endif
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lhs_sh_q <= '0;
      rhs_sh_q <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
      lhs_sign_q <= 1'b0;
      rhs_sign_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lhs_sh_q <= lhs_sh_d;
      rhs_sh_q <= rhs_sh_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
      lhs_sign_q <= lhs_sign_d;
      rhs_sign_q <= rhs_sign_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.io_in_ready  = (state_q == IDLE);
  assign bus.io_out_valid = (state_q == DONE);
  assign bus.io_out_sum   = sum_q;
  assign bus.io_out_cout  = cout_q;
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
  assign bus.io_out_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder (WIDTH=8 and WIDTH=2 instances) against an arithmetic model.
module tb_serial_digit_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_digit_adder_if #(.WIDTH(8)) bus ();
  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  serial_digit_adder_if #(.WIDTH(2)) bus2 ();
  serial_digit_adder #(.WIDTH(2), .DIGIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: true sum in W+1 bits; overflow when the signed sum leaves the signed W-bit range.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] l, input logic [W-1:0] r, input logic c);
    int unsigned t;
    t = int'(l) + int'(r) + int'(c);
    return t[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] l, input logic [W-1:0] r, input logic c);
    int s;
    s = int'($signed(l)) + int'($signed(r)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  function automatic logic get_ovf();
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
    return bus.io_out_overflow;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation with io_out_ready high; lat = -1 when no result appears in time.
  task automatic do_op(input logic [W-1:0] l, input logic [W-1:0] r, input logic c,
                       output int lat, output logic [W-1:0] s, output logic co, output logic ov);
    bus.io_out_ready = 1'b1;
    bus.io_in_lhs = l;
    bus.io_in_rhs = r;
    bus.io_in_cin = c;
    bus.io_in_valid = 1'b1;
    tick();
    bus.io_in_valid = 1'b0;
    bus.io_in_lhs = W'($urandom);
    bus.io_in_rhs = W'($urandom);
    lat = 0;
    while (!bus.io_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.io_out_valid) lat = -1;
    s  = bus.io_out_sum;
    co = bus.io_out_cout;
    ov = get_ovf();
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.io_in_ready); end
    checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.io_out_valid); end
    checks++; if (bus.io_out_sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", bus.io_out_sum); end
    checks++; if (bus.io_out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", bus.io_out_cout); end
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
    checks++; if (bus.io_out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.io_out_overflow); end
`endif
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int lat; logic [W-1:0] s; logic co, ov;
    logic [W-1:0] vl [2] = '{8'h5A, 8'hFF};
    logic [W-1:0] vr [2] = '{8'h3C, 8'h00};
    logic         vc [2] = '{1'b0, 1'b1};
    logic [W-1:0] es [2] = '{8'h96, 8'h00};
    logic         ec [2] = '{1'b0, 1'b1};
    logic         eo [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      do_op(vl[i], vr[i], vc[i], lat, s, co, ov);
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got %0d exp 4", i, lat); end
      checks++; if (s !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", i, s, es[i]); end
      checks++; if (co !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", i, co, ec[i]); end
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
      checks++; if (ov !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b exp %b", i, ov, eo[i]); end
`endif
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.io_out_ready = 1'b0;
    bus.io_in_lhs = 8'h5A; bus.io_in_rhs = 8'h3C; bus.io_in_cin = 1'b0;
    bus.io_in_valid = 1'b1;
    tick();
    bus.io_in_valid = 1'b0;
    n = 0;
    while (!bus.io_out_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.io_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", i, bus.io_out_valid); end
      checks++; if (bus.io_out_sum !== 8'h96) begin errors++; $display("FAIL bp_hold_sum cyc %0d got %h exp 96", i, bus.io_out_sum); end
      checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, bus.io_in_ready); end
      tick();
    end
    checks++; if (bus.io_out_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b exp 1", bus.io_out_valid); end
    bus.io_out_ready = 1'b1;
    tick();
    checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", bus.io_out_valid); end
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.io_in_ready); end
    checks++; if (bus.io_out_sum !== 8'h96) begin errors++; $display("FAIL bp_sum_kept got %h exp 96", bus.io_out_sum); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [W-1:0] s; logic co, ov; logic seen;
    bus.io_out_ready = 1'b1;
    bus.io_in_lhs = 8'hFF; bus.io_in_rhs = 8'hFF; bus.io_in_cin = 1'b0;
    bus.io_in_valid = 1'b1;
    tick();
    bus.io_in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", bus.io_in_ready); end
    checks++; if (bus.io_out_sum !== 8'h00) begin errors++; $display("FAIL rmid_sum_cleared got %h exp 00", bus.io_out_sum); end
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.io_out_valid) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_result got %b exp 0", seen); end
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got %b exp 1", bus.io_in_ready); end
    do_op(8'h01, 8'h01, 1'b0, lat, s, co, ov);
    checks++; if (s !== 8'h02) begin errors++; $display("FAIL rmid_next_sum got %h exp 02", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL rmid_next_cout got %b exp 0", co); end
  endtask

  task automatic test_ignore_busy();
    int n;
    bus.io_out_ready = 1'b1;
    bus.io_in_lhs = 8'h10; bus.io_in_rhs = 8'h20; bus.io_in_cin = 1'b0;
    bus.io_in_valid = 1'b1;
    tick();
    bus.io_in_lhs = 8'h11; bus.io_in_rhs = 8'h22;
    n = 0;
    while (!bus.io_out_valid && n < 20) begin tick(); n++; end
    checks++; if (bus.io_out_sum !== 8'h30) begin errors++; $display("FAIL busy_first_sum got %h exp 30", bus.io_out_sum); end
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL busy_done_ready got %b exp 0", bus.io_in_ready); end
    tick();
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL busy_back_idle got %b exp 1", bus.io_in_ready); end
    tick();
    bus.io_in_valid = 1'b0;
    n = 0;
    while (!bus.io_out_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL busy_second_latency got %0d exp 4", n); end
    checks++; if (bus.io_out_sum !== 8'h33) begin errors++; $display("FAIL busy_second_sum got %h exp 33", bus.io_out_sum); end
    tick();
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] s, l, r; logic co, ov, c; logic [W:0] e;
    for (int i = 0; i < 40; i++) begin
      l = W'($urandom); r = W'($urandom); c = 1'($urandom);
      e = ref_sum(l, r, c);
      do_op(l, r, c, lat, s, co, ov);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rnd%0d_latency got %0d exp 4", i, lat); end
      checks++; if ({co, s} !== e) begin errors++; $display("FAIL rnd%0d_sum %h+%h+%b got %b_%h exp %b_%h", i, l, r, c, co, s, e[W], e[W-1:0]); end
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
      checks++; if (ov !== ref_ovf(l, r, c)) begin errors++; $display("FAIL rnd%0d_ovf got %b exp %b", i, ov, ref_ovf(l, r, c)); end
`endif
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
  endtask

  task automatic test_width2();
    int n;
    bus2.io_out_ready = 1'b1;
    bus2.io_in_lhs = 2'd3; bus2.io_in_rhs = 2'd3; bus2.io_in_cin = 1'b1;
    bus2.io_in_valid = 1'b1;
    tick();
    bus2.io_in_valid = 1'b0;
    n = 0;
    while (!bus2.io_out_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 1) begin errors++; $display("FAIL w2_latency got %0d exp 1", n); end
    checks++; if (bus2.io_out_sum !== 2'd3) begin errors++; $display("FAIL w2_sum got %0d exp 3", bus2.io_out_sum); end
    checks++; if (bus2.io_out_cout !== 1'b1) begin errors++; $display("FAIL w2_cout got %b exp 1", bus2.io_out_cout); end
`ifdef SERIAL_DIGIT_ADDER_OVERFLOW_EN
    checks++; if (bus2.io_out_overflow !== 1'b0) begin errors++; $display("FAIL w2_ovf got %b exp 0", bus2.io_out_overflow); end
`endif
    tick();
  endtask

  initial begin
    bus.io_in_valid = 1'b0; bus.io_in_lhs = '0; bus.io_in_rhs = '0; bus.io_in_cin = 1'b0; bus.io_out_ready = 1'b1;
    bus2.io_in_valid = 1'b0; bus2.io_in_lhs = '0; bus2.io_in_rhs = '0; bus2.io_in_cin = 1'b0; bus2.io_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_ignore_busy();
    test_random();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
